cpu_run_monitor: RTL and testbench



---
 rtl/cpu_run_monitor_pkg.sv | 21 ++
 rtl/cpu_run_monitor_if.sv | 14 +
 rtl/cpu_run_monitor_trace.sv | 44 ++++
 rtl/cpu_run_monitor.sv | 179 +++++++++++++++++
 tb/tb_cpu_run_monitor.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_monitor_pkg.sv
// Shared types and codes for the CPU run monitor: FSM states, dump beat kinds
// and stop reasons.
package cpu_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN_TRACE,
    ST_DUMP_REGS,
    ST_DONE
  } mon_state_t;

  localparam logic [1:0] KIND_TRACE_PC   = 2'd0;
  localparam logic [1:0] KIND_TRACE_INST = 2'd1;
  localparam logic [1:0] KIND_REG        = 2'd2;

  localparam logic [1:0] STOP_NONE  = 2'd0;
  localparam logic [1:0] STOP_LIMIT = 2'd1;
  localparam logic [1:0] STOP_HALT  = 2'd2;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// Dump stream port: one beat per valid&ready, with a kind code and an 8-bit
// tag (trace entry number or register index).
interface cpu_run_monitor_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [1:0]        kind;
  logic [7:0]        tag;

  modport master (output valid, data, kind, tag, input ready);
  modport slave  (input valid, data, kind, tag, output ready);
endinterface

// File: rtl/cpu_run_monitor_trace.sv
// Fetch trace ring buffer: single write port, async read indexed from the
// oldest entry; once full, each push overwrites the oldest entry.
module trace_ring_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] oldest;
  logic [PTR_W-1:0] rd_addr;
  logic             full;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  // When full, the write pointer already points at the oldest entry.
  assign oldest  = full ? wr_ptr : '0;
  assign rd_addr = oldest + rd_idx;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (!full) count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !(rst || clear)) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run controller for the multi-cycle CPU: gates execution, stops on a cycle
// limit or halt loop, then streams the fetch trace and a register dump.
//
//   state          | meaning
//   ST_IDLE        | after reset, waiting for start
//   ST_RUN         | cpu_run=1, counting cycles, recording fetches
//   ST_DRAIN_TRACE | emitting PC/INST beat pairs, oldest entry first
//   ST_DUMP_REGS   | emitting one REG beat per register index
//   ST_DONE        | dump finished, status frozen until start
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_CYCLES  = 40,
  parameter int TRACE_DEPTH = 16,
  parameter int REG_COUNT   = 32,
  parameter int REG_IDX_W   = 5,
  parameter int HALT_REPEAT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    pc_in,
  input  logic [DATA_W-1:0]    inst_in,
  input  logic                 inst_valid,
  output logic                 cpu_run,
  output logic [REG_IDX_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0]    rf_rdata,
  cpu_run_monitor_if.master    dump,
  output logic                 done,
  output logic [1:0]           stop_reason,
  output logic [31:0]          cycle_count,
  output logic [31:0]          inst_count
);
  localparam int TRC_W = $clog2(TRACE_DEPTH);
  localparam int HR_W  = $clog2(HALT_REPEAT + 1);

  mon_state_t state, state_nxt;

  logic [31:0]               run_timer;
  logic [ADDR_W-1:0]         prev_pc;
  logic                      have_prev;
  logic [HR_W-1:0]           repeat_cnt;
  logic [TRC_W-1:0]          trace_idx;
  logic                      beat_inst;
  logic [REG_IDX_W-1:0]      reg_idx;
  logic [ADDR_W+DATA_W-1:0]  trc_rdata;
  logic [TRC_W:0]            trc_count;

  logic launch, push, same_pc, halt_hit, limit_hit, trace_empty_nxt;
  logic beat_fire, last_entry, last_reg;

  assign launch          = ((state == ST_IDLE) || (state == ST_DONE)) && start;
  assign push            = (state == ST_RUN) && inst_valid;
  assign same_pc         = have_prev && (pc_in == prev_pc);
  assign halt_hit        = push && same_pc && ((repeat_cnt + 1'b1) == HR_W'(HALT_REPEAT - 1));
  assign limit_hit       = (state == ST_RUN) && (run_timer == '0);
  // A fetch in the stopping cycle still lands in the trace.
  assign trace_empty_nxt = (trc_count == '0) && !push;
  assign beat_fire       = dump.valid && dump.ready;
  assign last_entry      = ({1'b0, trace_idx} == (trc_count - 1'b1));
  assign last_reg        = (reg_idx == REG_IDX_W'(REG_COUNT - 1));

  assign cpu_run = (state == ST_RUN);
  assign done    = (state == ST_DONE);

  trace_ring_buffer #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (ADDR_W + DATA_W)
  ) u_trace (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .push    (push),
    .wdata   ({pc_in, inst_in}),
    .rd_idx  (trace_idx),
    .rd_data (trc_rdata),
    .count   (trc_count)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    dump.valid = 1'b0;
    dump.data  = '0;
    dump.kind  = KIND_TRACE_PC;
    dump.tag   = '0;
    rf_raddr   = '0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_hit || limit_hit)
          state_nxt = trace_empty_nxt ? ST_DUMP_REGS : ST_DRAIN_TRACE;
      end
      ST_DRAIN_TRACE: begin
        dump.valid = 1'b1;
        dump.tag   = 8'(trace_idx);
        if (beat_inst) begin
          dump.kind = KIND_TRACE_INST;
          dump.data = trc_rdata[DATA_W-1:0];
        end else begin
          dump.kind = KIND_TRACE_PC;
          dump.data = DATA_W'(trc_rdata[ADDR_W+DATA_W-1:DATA_W]);
        end
        if (beat_fire && beat_inst && last_entry) state_nxt = ST_DUMP_REGS;
      end
      ST_DUMP_REGS: begin
        dump.valid = 1'b1;
        dump.kind  = KIND_REG;
        dump.tag   = 8'(reg_idx);
        dump.data  = rf_rdata;
        rf_raddr   = reg_idx;
        if (beat_fire && last_reg) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      inst_count  <= '0;
      stop_reason <= STOP_NONE;
      run_timer   <= '0;
      prev_pc     <= '0;
      have_prev   <= 1'b0;
      repeat_cnt  <= '0;
      trace_idx   <= '0;
      beat_inst   <= 1'b0;
      reg_idx     <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cycle_count <= '0;
            inst_count  <= '0;
            stop_reason <= STOP_NONE;
            run_timer   <= 32'(MAX_CYCLES - 1);
            have_prev   <= 1'b0;
            repeat_cnt  <= '0;
            trace_idx   <= '0;
            beat_inst   <= 1'b0;
            reg_idx     <= '0;
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_count + 32'd1;
          if (run_timer != '0) run_timer <= run_timer - 32'd1;
          if (inst_valid) begin
            inst_count <= inst_count + 32'd1;
            prev_pc    <= pc_in;
            have_prev  <= 1'b1;
            repeat_cnt <= same_pc ? repeat_cnt + 1'b1 : '0;
          end
          if (halt_hit)       stop_reason <= STOP_HALT;
          else if (limit_hit) stop_reason <= STOP_LIMIT;
        end
        ST_DRAIN_TRACE: begin
          if (beat_fire) begin
            beat_inst <= ~beat_inst;
            if (beat_inst) trace_idx <= trace_idx + 1'b1;
          end
        end
        ST_DUMP_REGS: begin
          if (beat_fire) reg_idx <= reg_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: stimulus queues the expected dump
// beats, a monitor pops and compares each transferred beat.
`timescale 1ns/1ps
module tb_cpu_run_monitor;
  import cpu_mon_pkg::*;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  tag;
    logic [31:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        inst_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic        cpu_run, done;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [1:0]  stop_reason;
  logic [31:0] cycle_count, inst_count;
  logic [31:0] rf [32];

  beat_t       expq[$];
  logic [31:0] fpc[$];
  logic [31:0] model[$];
  int          errors = 0;
  int          checks = 0;
  int          run_cycles = 0;
  bit          ready_toggle = 1'b0;
  int          ph = 0;
  logic [3:0]  pat = 4'b1001;

  cpu_run_monitor_if #(.DATA_W(32)) dump ();

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  cpu_run_monitor dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pc_in       (pc_in),
    .inst_in     (inst_in),
    .inst_valid  (inst_valid),
    .cpu_run     (cpu_run),
    .rf_raddr    (rf_raddr),
    .rf_rdata    (rf_rdata),
    .dump        (dump),
    .done        (done),
    .stop_reason (stop_reason),
    .cycle_count (cycle_count),
    .inst_count  (inst_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h8C00_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ready pattern 1,0,0,1 when toggling, otherwise held high
  initial begin
    dump.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_toggle) begin
        dump.ready = pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        dump.ready = 1'b1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cpu_run) run_cycles++;
  end

  // monitor: compares every transferred beat and the hold behaviour on stalls
  initial begin
    beat_t held, got, exp;
    bit stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        got = {dump.kind, dump.tag, dump.data};
        if (stalled) begin
          checks++;
          if (!dump.valid || got !== held) begin
            errors++;
            $display("FAIL stall_hold: got v=%0b k=%0d t=%0d d=%h expected v=1 k=%0d t=%0d d=%h",
                     dump.valid, got.kind, got.tag, got.data, held.kind, held.tag, held.data);
          end
        end
        stalled = dump.valid && !dump.ready;
        held = got;
        if (dump.valid && dump.ready) begin
          checks++;
          if (expq.size() == 0) begin
            errors++;
            $display("FAIL beat_unexpected: got k=%0d t=%0d d=%h expected no beat",
                     got.kind, got.tag, got.data);
          end else begin
            exp = expq.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL beat: got k=%0d t=%0d d=%h expected k=%0d t=%0d d=%h",
                       got.kind, got.tag, got.data, exp.kind, exp.tag, exp.data);
            end
          end
        end
      end
    end
  end

  task automatic do_start();
    run_cycles = 0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // drives ncyc RUN cycles; fetches from fpc every 'period' cycles
  task automatic drive_run(input int ncyc, input int period, input int start_k);
    int j = 0;
    model.delete();
    for (int k = 0; k < ncyc; k++) begin
      if (period > 0 && (k % period) == 0 && j < fpc.size()) begin
        inst_valid = 1'b1;
        pc_in      = fpc[j];
        inst_in    = inst_of(fpc[j]);
        model.push_back(fpc[j]);
        if (model.size() > 16) void'(model.pop_front());
        j++;
      end else begin
        inst_valid = 1'b0;
      end
      start = (k == start_k);
      @(posedge clk);
      #1;
    end
    inst_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < model.size(); i++) begin
      expq.push_back({KIND_TRACE_PC,   8'(i), model[i]});
      expq.push_back({KIND_TRACE_INST, 8'(i), inst_of(model[i])});
    end
    for (int i = 0; i < 32; i++)
      expq.push_back({KIND_REG, 8'(i), 32'(i) * 32'h11});
  endtask

  task automatic finish_run(input logic [1:0] exp_stop, input int exp_inst, input int exp_cyc);
    int t = 0;
    while (!done && t < 600) begin
      @(posedge clk);
      #1;
      t++;
    end
    check32("done_seen", 32'(done), 32'd1);
    check32("valid_in_done", 32'(dump.valid), 32'd0);
    check32("stop_reason", 32'(stop_reason), 32'(exp_stop));
    check32("inst_count", inst_count, 32'(exp_inst));
    check32("cycle_count", cycle_count, 32'(exp_cyc));
    check32("cpu_run_cycles", 32'(run_cycles), 32'(exp_cyc));
    check32("beats_missing", 32'(expq.size()), 32'd0);
  endtask

  task automatic limit_run();
    fpc.delete();
    for (int i = 0; i < 10; i++) fpc.push_back(32'h3000 + 32'(4 * i));
    do_start();
    drive_run(40, 4, -1);
    push_expected();
    finish_run(STOP_LIMIT, 10, 40);
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;

    repeat (3) @(posedge clk);
    #1;
    check32("rst_cpu_run", 32'(cpu_run), 32'd0);
    check32("rst_valid", 32'(dump.valid), 32'd0);
    check32("rst_done", 32'(done), 32'd0);
    check32("rst_stop", 32'(stop_reason), 32'd0);
    check32("rst_cycles", cycle_count, 32'd0);
    check32("rst_insts", inst_count, 32'd0);
    rst = 1'b0;

    // cycle-limit stop, fetch every 4th cycle
    limit_run();

    // halt loop with stalling sink: 0x3000, 0x3004, 0x3008 x3
    fpc.delete();
    fpc.push_back(32'h3000);
    fpc.push_back(32'h3004);
    fpc.push_back(32'h3008);
    fpc.push_back(32'h3008);
    fpc.push_back(32'h3008);
    ready_toggle = 1'b1;
    do_start();
    drive_run(5, 1, -1);
    push_expected();
    finish_run(STOP_HALT, 5, 5);
    ready_toggle = 1'b0;

    // 20 fetches overflow the ring; start mid-run must be ignored
    fpc.delete();
    for (int i = 0; i < 20; i++) fpc.push_back(32'h4000 + 32'(4 * i));
    do_start();
    drive_run(40, 1, 10);
    check32("ring_oldest_pc", model[0], 32'h4010);
    push_expected();
    finish_run(STOP_LIMIT, 20, 40);

    // start from DONE clears status; then reset in the middle of the reg dump
    fpc.delete();
    do_start();
    check32("restart_cpu_run", 32'(cpu_run), 32'd1);
    check32("restart_done", 32'(done), 32'd0);
    check32("restart_cycles", cycle_count, 32'd0);
    check32("restart_insts", inst_count, 32'd0);
    check32("restart_stop", 32'(stop_reason), 32'd0);
    drive_run(40, 0, -1);
    push_expected();
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      @(negedge clk);
      if (dump.valid && dump.kind == KIND_REG && dump.tag == 8'd10) found = 1'b1;
    end
    check32("reg10_reached", 32'(found), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    check32("abort_valid", 32'(dump.valid), 32'd0);
    check32("abort_done", 32'(done), 32'd0);
    check32("abort_cpu_run", 32'(cpu_run), 32'd0);
    check32("abort_stop", 32'(stop_reason), 32'd0);
    check32("abort_cycles", cycle_count, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check32("idle_valid", 32'(dump.valid), 32'd0);

    // full replay after the abort
    limit_run();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
